iomem_led_bank: RTL

Parametrised LED/GPIO output peripheral on the PicoSoC `iomem` bus, the successor to the fixed single-register GPIO ports in the board top level. Provides NUM_CH output channels with atomic set/clear/toggle access and a per-channel PWM dimming mode driven by a shared prescaler. It is instantiated in the board top, decoded by `iomem_addr[31:24] == BASE_HI`, and drives LED pins directly.

---
 rtl/iomem_led_pkg.sv | 22 ++
 rtl/led_pwm_channel.sv | 26 ++
 rtl/iomem_led_bank.sv | 116 +++++++++++
 3 files changed

// File: rtl/iomem_led_pkg.sv
// Shared register offsets, channel mode encoding and byte-strobe helper
// for the iomem LED/GPIO bank.
package iomem_led_pkg;

    localparam logic [7:0] OFS_OUT       = 8'h00;
    localparam logic [7:0] OFS_SET       = 8'h04;
    localparam logic [7:0] OFS_CLR       = 8'h08;
    localparam logic [7:0] OFS_TOG       = 8'h0C;
    localparam logic [7:0] OFS_MODE      = 8'h10;
    localparam logic [7:0] OFS_PRESCALE  = 8'h14;
    localparam logic [7:0] OFS_DUTY_BASE = 8'h20;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_PWM    = 1'b1
    } ch_mode_e;

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One output channel: registered pin driven either by the direct OUT bit
// or by comparing the shared PWM counter against this channel's duty.
module led_pwm_channel
    import iomem_led_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  ch_mode_e            mode,
    input  logic                out_bit,
    input  logic [PWM_BITS-1:0] duty,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            led <= 1'b0;
        else if (mode == MODE_PWM)
            led <= (pwm_cnt < duty);
        else
            led <= out_bit;
    end

endmodule

// File: rtl/iomem_led_bank.sv
// LED/GPIO bank on the PicoSoC iomem bus: OUT/SET/CLR/TOG/MODE/PRESCALE
// and per-channel DUTY registers, shared prescaler and PWM counter.
module iomem_led_bank
    import iomem_led_pkg::*;
#(
    parameter int         NUM_CH        = 8,
    parameter int         PWM_BITS      = 8,
    parameter int         PRESCALE_BITS = 16,
    parameter logic [7:0] BASE_HI       = 8'h05
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              iomem_valid,
    output logic              iomem_ready,
    input  logic [3:0]        iomem_wstrb,
    input  logic [31:0]       iomem_addr,
    input  logic [31:0]       iomem_wdata,
    output logic [31:0]       iomem_rdata,
    output logic [NUM_CH-1:0] led_o
);

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]                out_r;
    logic [NUM_CH-1:0]                mode_r;
    logic [PRESCALE_BITS-1:0]         pre_r;
    logic [NUM_CH-1:0][PWM_BITS-1:0]  duty_r;
    logic [PRESCALE_BITS-1:0]         pre_cnt;
    logic [PWM_BITS-1:0]              pwm_cnt;

    logic        req, wr, tick, pre_wr, duty_hit;
    logic [7:0]  ofs;
    logic [5:0]  duty_word;
    logic [IW-1:0] duty_idx;
    logic [31:0] m, wd, rd;

    // Accept only when idle so each access yields exactly one ready pulse.
    assign req       = iomem_valid && (iomem_addr[31:24] == BASE_HI) && !iomem_ready;
    assign wr        = req && (iomem_wstrb != 4'b0000);
    assign ofs       = {iomem_addr[7:2], 2'b00};
    assign m         = strb_mask(iomem_wstrb);
    assign wd        = iomem_wdata & m;
    assign duty_word = iomem_addr[7:2] - OFS_DUTY_BASE[7:2];
    assign duty_hit  = (ofs >= OFS_DUTY_BASE) && (int'(duty_word) < NUM_CH);
    assign duty_idx  = duty_word[IW-1:0];
    assign tick      = (pre_cnt == pre_r);
    assign pre_wr    = wr && (ofs == OFS_PRESCALE);

    always_comb begin
        rd = '0;
        case (ofs)
            OFS_OUT, OFS_SET, OFS_CLR, OFS_TOG: rd[NUM_CH-1:0]        = out_r;
            OFS_MODE:                           rd[NUM_CH-1:0]        = mode_r;
            OFS_PRESCALE:                       rd[PRESCALE_BITS-1:0] = pre_r;
            default: if (duty_hit)              rd[PWM_BITS-1:0]      = duty_r[duty_idx];
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
        end else begin
            iomem_ready <= req;
            iomem_rdata <= req ? rd : '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_r  <= '0;
            mode_r <= '0;
            pre_r  <= '0;
            duty_r <= '0;
        end else if (wr) begin
            case (ofs)
                OFS_OUT:      out_r  <= (out_r & ~m[NUM_CH-1:0]) | wd[NUM_CH-1:0];
                OFS_SET:      out_r  <= out_r | wd[NUM_CH-1:0];
                OFS_CLR:      out_r  <= out_r & ~wd[NUM_CH-1:0];
                OFS_TOG:      out_r  <= out_r ^ wd[NUM_CH-1:0];
                OFS_MODE:     mode_r <= (mode_r & ~m[NUM_CH-1:0]) | wd[NUM_CH-1:0];
                OFS_PRESCALE: pre_r  <= (pre_r & ~m[PRESCALE_BITS-1:0]) | wd[PRESCALE_BITS-1:0];
                default: if (duty_hit)
                    duty_r[duty_idx] <= (duty_r[duty_idx] & ~m[PWM_BITS-1:0]) | wd[PWM_BITS-1:0];
            endcase
        end
    end

    // A PRESCALE write restarts the count even on a tick; pwm_cnt still advances.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            pre_cnt <= (pre_wr || tick) ? '0 : pre_cnt + 1'b1;
            if (tick)
                pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
            .clk     (clk),
            .resetn  (resetn),
            .mode    (ch_mode_e'(mode_r[i])),
            .out_bit (out_r[i]),
            .duty    (duty_r[i]),
            .pwm_cnt (pwm_cnt),
            .led     (led_o[i])
        );
    end

    logic unused_bits;
    assign unused_bits = ^{iomem_addr[23:8], iomem_addr[1:0], m, wd, duty_word};

endmodule
